// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/step/halt controller.
//   run_state_e : controller state encoding, also driven on the `state` output
//   TICK_W      : width of the cpu_ce pulse counter shown on the display
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HALT = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } run_state_e;

    localparam int unsigned TICK_W = 5;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Bus between the run controller and the boot ROM / instruction memory / core.
//   boot_addr, boot_data             : boot ROM read port
//   mem_we, mem_waddr, mem_wdata     : instruction memory write port
//   cpu_rst, cpu_ce, cpu_pc          : core reset, clock enable and current PC
// master = controller side, slave = memory/core side.
interface cpu_run_ctrl_if #(
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] boot_addr;
    logic [31:0]       boot_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              cpu_ce;
    logic [ADDR_W-1:0] cpu_pc;

    modport master (
        output boot_addr, mem_we, mem_waddr, mem_wdata, cpu_rst, cpu_ce,
        input  boot_data, cpu_pc
    );

    modport slave (
        input  boot_addr, mem_we, mem_waddr, mem_wdata, cpu_rst, cpu_ce,
        output boot_data, cpu_pc
    );

endinterface

// File: rtl/ce_divider.sv
// Free-running modulo-DIV_MAX counter giving the RUN-mode instruction cadence.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force the count to 0 (has priority over enable)
//   enable   : advance the count by one per cycle, wrapping DIV_MAX-1 -> 0
//   tick     : one-cycle pulse in the cycle whose edge moves the count onto
//              DIV_MAX-1, so a registered consumer fires alongside that count
module ce_divider #(
    parameter int unsigned DIV_MAX = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(DIV_MAX - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(DIV_MAX - 2);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tick = enable && !clear && (cnt_q == PRE_LAST);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller for the MIPS core: boot-copies the instruction
// memory from ROM after reset, then sequences the core with one-cycle enables.
//   clk, rst                     : system clock, synchronous active-high reset
//   run_btn, step_btn, halt_btn  : one-cycle request pulses (halt > run > step)
//   bp_en, bp_addr               : PC breakpoint, checked every RUN cycle
//   bus                          : boot ROM, instruction memory and core signals
//   state                        : LOAD=0, HALT=1, RUN=2, STEP=3
//   tick_cnt                     : cpu_ce pulses seen, mod 32
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DIV_MAX    = 10_000_000,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned BOOT_WORDS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_btn,
    input  logic              step_btn,
    input  logic              halt_btn,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    cpu_run_ctrl_if.master    bus,
    output logic [1:0]        state,
    output logic [TICK_W-1:0] tick_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BOOT_WORDS - 1);

    run_state_e        state_q;
    logic              cpu_rst_q;
    logic              cpu_ce_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] boot_addr_q;
    logic [ADDR_W-1:0] mem_waddr_q;
    logic [31:0]       mem_wdata_q;
    logic [TICK_W-1:0] tick_cnt_q;
    // Set once the last ROM address has been consumed; the next cycle leaves LOAD.
    logic              issue_done_q;

    logic stop;
    logic div_tick;

    // Any stop condition in RUN both halts and swallows the tick due this cycle.
    assign stop = halt_btn || (bp_en && (bus.cpu_pc == bp_addr));

    // Divider is held at 0 outside RUN, so entering RUN always starts a full period.
    ce_divider #(
        .DIV_MAX (DIV_MAX)
    ) u_ce_divider (
        .clk    (clk),
        .rst    (rst),
        .clear  ((state_q != ST_RUN) || stop),
        .enable (state_q == ST_RUN),
        .tick   (div_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            cpu_rst_q    <= 1'b1;
            cpu_ce_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            boot_addr_q  <= '0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            tick_cnt_q   <= '0;
            issue_done_q <= 1'b0;
        end else begin
            cpu_ce_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (cpu_ce_q) begin
                tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            end

            unique case (state_q)
                ST_LOAD: begin
                    if (!issue_done_q) begin
                        // ROM data for boot_addr_q is valid at this edge.
                        mem_we_q    <= 1'b1;
                        mem_waddr_q <= boot_addr_q;
                        mem_wdata_q <= bus.boot_data;
                        if (boot_addr_q == LAST_ADDR) begin
                            issue_done_q <= 1'b1;
                        end else begin
                            boot_addr_q <= boot_addr_q + ADDR_W'(1);
                        end
                    end else begin
                        state_q   <= ST_HALT;
                        cpu_rst_q <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (!halt_btn) begin
                        if (run_btn) begin
                            state_q <= ST_RUN;
                        end else if (step_btn) begin
                            state_q  <= ST_STEP;
                            cpu_ce_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q <= ST_HALT;
                    end else begin
                        cpu_ce_q <= div_tick;
                    end
                end
                ST_STEP: begin
                    // Breakpoint and halt are both ignored here.
                    state_q <= ST_HALT;
                end
                default: state_q <= ST_HALT;
            endcase
        end
    end

    assign bus.boot_addr = boot_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_waddr = mem_waddr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.cpu_ce    = cpu_ce_q;
    assign state         = state_q;
    assign tick_cnt      = tick_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;
    import cpu_ctrl_pkg::*;

    localparam int unsigned DIV_MAX    = 4;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned BOOT_WORDS = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              run_btn  = 1'b0;
    logic              step_btn = 1'b0;
    logic              halt_btn = 1'b0;
    logic              bp_en    = 1'b0;
    logic [ADDR_W-1:0] bp_addr  = '0;
    logic [1:0]        state;
    logic [TICK_W-1:0] tick_cnt;
    logic [ADDR_W-1:0] pc;

    int n_cmp     = 0;
    int n_bad     = 0;
    int cyc       = 0;
    int exp_tick  = 0;
    int run_start = 0;

    wr_t exp_wr[$];
    int  exp_ce[$];

    cpu_run_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    cpu_run_ctrl #(
        .DIV_MAX    (DIV_MAX),
        .ADDR_W     (ADDR_W),
        .BOOT_WORDS (BOOT_WORDS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run_btn  (run_btn),
        .step_btn (step_btn),
        .halt_btn (halt_btn),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .bus      (bus),
        .state    (state),
        .tick_cnt (tick_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Boot ROM: word k holds A000_0000 + k, sampled at the edge after boot_addr.
    assign bus.boot_data = 32'hA000_0000 + 32'(bus.boot_addr);

    // Core model: PC cleared while held in reset, advances on each cpu_ce.
    always @(posedge clk) begin
        if (bus.cpu_rst === 1'b1) pc <= '0;
        else if (bus.cpu_ce === 1'b1) pc <= pc + ADDR_W'(1);
    end
    assign bus.cpu_pc = pc;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (state !== ST_LOAD) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", state, ST_LOAD); end
        n_cmp++; if (bus.cpu_rst !== 1'b1) begin n_bad++; $display("FAIL reset_cpu_rst: got %b want 1", bus.cpu_rst); end
        n_cmp++; if (bus.cpu_ce !== 1'b0 || bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_strobes: ce=%b we=%b want 0/0", bus.cpu_ce, bus.mem_we); end
        n_cmp++; if (bus.boot_addr !== '0 || bus.mem_waddr !== '0 || bus.mem_wdata !== '0) begin n_bad++; $display("FAIL reset_addr_data: boot_addr=%0h waddr=%0h wdata=%0h want 0", bus.boot_addr, bus.mem_waddr, bus.mem_wdata); end
        n_cmp++; if (tick_cnt !== '0) begin n_bad++; $display("FAIL reset_tick_cnt: got %0d want 0", tick_cnt); end
    endtask

    task automatic test_boot();
        wr_t w;
        exp_wr.delete();
        for (int k = 0; k < int'(BOOT_WORDS); k++) exp_wr.push_back({ADDR_W'(k), 32'hA000_0000 + 32'(k)});
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.mem_we === 1'b1) begin
                n_cmp++;
                if (exp_wr.size() == 0) begin
                    n_bad++; $display("FAIL boot_write: extra write addr=%0h at cycle %0d", bus.mem_waddr, i);
                end else begin
                    w = exp_wr.pop_front();
                    if (bus.mem_waddr !== w.addr || bus.mem_wdata !== w.data || i != int'(w.addr) + 1) begin
                        n_bad++;
                        $display("FAIL boot_write: got addr=%0h data=%0h cycle %0d want addr=%0h data=%0h cycle %0d",
                                 bus.mem_waddr, bus.mem_wdata, i, w.addr, w.data, int'(w.addr) + 1);
                    end
                end
            end
            if (i <= 16) begin
                n_cmp++; if (bus.cpu_rst !== 1'b1 || bus.cpu_ce !== 1'b0) begin n_bad++; $display("FAIL boot_cpu_rst: cycle %0d cpu_rst=%b cpu_ce=%b want 1/0", i, bus.cpu_rst, bus.cpu_ce); end
            end
            if (i == 16) begin
                n_cmp++; if (state !== ST_LOAD) begin n_bad++; $display("FAIL boot_still_load: got %0d want %0d", state, ST_LOAD); end
            end
            if (i == 17) begin
                n_cmp++; if (state !== ST_HALT || bus.cpu_rst !== 1'b0) begin n_bad++; $display("FAIL boot_halt: state=%0d cpu_rst=%b want %0d/0", state, bus.cpu_rst, ST_HALT); end
            end
        end
        n_cmp++; if (exp_wr.size() != 0) begin n_bad++; $display("FAIL boot_missing: %0d writes not seen, want 0", exp_wr.size()); end
    endtask

    task automatic test_priority();
        run_btn   = 1'b1;
        step_btn  = 1'b1;
        run_start = cyc;
        @(negedge clk);
        run_btn  = 1'b0;
        step_btn = 1'b0;
        n_cmp++; if (state !== ST_RUN) begin n_bad++; $display("FAIL prio_state: got %0d want %0d", state, ST_RUN); end
        n_cmp++; if (bus.cpu_ce !== 1'b0) begin n_bad++; $display("FAIL prio_no_ce: got %b want 0", bus.cpu_ce); end
    endtask

    task automatic test_halt_collision();
        // Halt sampled on the edge that would raise the first cpu_ce (run_start+4).
        for (int i = 0; i < 8 && cyc < run_start + 3; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.cpu_ce !== 1'b0) begin n_bad++; $display("FAIL coll_early_ce: got %b want 0", bus.cpu_ce); end
        end
        halt_btn = 1'b1;
        @(negedge clk);
        halt_btn = 1'b0;
        n_cmp++; if (bus.cpu_ce !== 1'b0) begin n_bad++; $display("FAIL coll_ce: got %b want 0", bus.cpu_ce); end
        n_cmp++; if (state !== ST_HALT) begin n_bad++; $display("FAIL coll_state: got %0d want %0d", state, ST_HALT); end
        n_cmp++; if (tick_cnt !== TICK_W'(exp_tick)) begin n_bad++; $display("FAIL coll_tick_cnt: got %0d want %0d", tick_cnt, exp_tick); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.cpu_ce !== 1'b0) begin n_bad++; $display("FAIL coll_late_ce: got %b want 0", bus.cpu_ce); end
        end
    endtask

    task automatic test_run_cadence();
        exp_ce.delete();
        run_btn   = 1'b1;
        run_start = cyc;
        for (int j = 1; j <= 33; j++) exp_ce.push_back(run_start + int'(DIV_MAX) * j);
        @(negedge clk);
        run_btn = 1'b0;
        for (int i = 0; i < 136; i++) begin
            n_cmp++; if (tick_cnt !== TICK_W'(exp_tick)) begin n_bad++; $display("FAIL run_tick_cnt: cycle %0d got %0d want %0d", cyc - run_start, tick_cnt, exp_tick); end
            if (bus.cpu_ce === 1'b1) begin
                n_cmp++;
                if (exp_ce.size() == 0 || exp_ce[0] != cyc) begin
                    n_bad++; $display("FAIL run_ce: pulse at cycle %0d, next expected at %0d", cyc - run_start, (exp_ce.size() != 0) ? exp_ce[0] - run_start : -1);
                end else begin
                    void'(exp_ce.pop_front());
                end
                exp_tick = (exp_tick + 1) % 32;
            end else if (exp_ce.size() != 0 && exp_ce[0] == cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL run_ce: got 0 want 1 at cycle %0d", cyc - run_start);
                void'(exp_ce.pop_front());
            end
            if (cyc == run_start + 134) halt_btn = 1'b1;
            @(negedge clk);
            halt_btn = 1'b0;
        end
        n_cmp++; if (state !== ST_HALT) begin n_bad++; $display("FAIL run_halt: got %0d want %0d", state, ST_HALT); end
        n_cmp++; if (exp_ce.size() != 0) begin n_bad++; $display("FAIL run_missing: %0d pulses not seen, want 0", exp_ce.size()); end
        n_cmp++; if (tick_cnt !== 5'd1) begin n_bad++; $display("FAIL run_tick_wrap: got %0d want 1", tick_cnt); end
    endtask

    task automatic test_reset_mid_run();
        run_btn   = 1'b1;
        run_start = cyc;
        @(negedge clk);
        run_btn = 1'b0;
        // Divider reads 2 after the third edge of RUN.
        repeat (2) @(negedge clk);
        n_cmp++; if (state !== ST_RUN || bus.cpu_ce !== 1'b0) begin n_bad++; $display("FAIL mid_pre: state=%0d ce=%b want %0d/0", state, bus.cpu_ce, ST_RUN); end
        rst = 1'b1;
        @(negedge clk);
        exp_tick = 0;
        n_cmp++; if (state !== ST_LOAD || bus.cpu_rst !== 1'b1) begin n_bad++; $display("FAIL mid_reset_state: state=%0d cpu_rst=%b want %0d/1", state, bus.cpu_rst, ST_LOAD); end
        n_cmp++; if (bus.cpu_ce !== 1'b0 || bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL mid_reset_strobes: ce=%b we=%b want 0/0", bus.cpu_ce, bus.mem_we); end
        n_cmp++; if (bus.boot_addr !== '0 || bus.mem_waddr !== '0 || bus.mem_wdata !== '0) begin n_bad++; $display("FAIL mid_reset_bus: boot_addr=%0h waddr=%0h wdata=%0h want 0", bus.boot_addr, bus.mem_waddr, bus.mem_wdata); end
        n_cmp++; if (tick_cnt !== '0) begin n_bad++; $display("FAIL mid_reset_tick: got %0d want 0", tick_cnt); end
        rst = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (i == 1) begin
                n_cmp++; if (bus.mem_we !== 1'b1 || bus.mem_waddr !== '0 || bus.mem_wdata !== 32'hA000_0000) begin n_bad++; $display("FAIL mid_reload: we=%b waddr=%0h wdata=%0h want 1/0/a0000000", bus.mem_we, bus.mem_waddr, bus.mem_wdata); end
            end
        end
        n_cmp++; if (state !== ST_HALT) begin n_bad++; $display("FAIL mid_reboot_halt: got %0d want %0d", state, ST_HALT); end
    endtask

    task automatic test_breakpoint();
        exp_ce.delete();
        bp_en     = 1'b1;
        bp_addr   = ADDR_W'(5);
        run_btn   = 1'b1;
        run_start = cyc;
        // PC starts at 0, so the fifth pulse moves it onto the breakpoint.
        for (int j = 1; j <= 5; j++) exp_ce.push_back(run_start + int'(DIV_MAX) * j);
        @(negedge clk);
        run_btn = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.cpu_ce === 1'b1) begin
                n_cmp++;
                if (exp_ce.size() == 0 || exp_ce[0] != cyc) begin
                    n_bad++; $display("FAIL bp_ce: pulse at cycle %0d, next expected at %0d", cyc - run_start, (exp_ce.size() != 0) ? exp_ce[0] - run_start : -1);
                end else begin
                    void'(exp_ce.pop_front());
                end
            end else if (exp_ce.size() != 0 && exp_ce[0] == cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL bp_ce: got 0 want 1 at cycle %0d", cyc - run_start);
                void'(exp_ce.pop_front());
            end
            @(negedge clk);
        end
        n_cmp++; if (state !== ST_HALT) begin n_bad++; $display("FAIL bp_state: got %0d want %0d", state, ST_HALT); end
        n_cmp++; if (pc !== ADDR_W'(5)) begin n_bad++; $display("FAIL bp_pc: got %0d want 5", pc); end
        n_cmp++; if (exp_ce.size() != 0) begin n_bad++; $display("FAIL bp_missing: %0d pulses not seen, want 0", exp_ce.size()); end

        step_btn  = 1'b1;
        run_start = cyc;
        exp_ce.push_back(run_start + 1);
        @(negedge clk);
        step_btn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.cpu_ce === 1'b1) begin
                n_cmp++;
                if (exp_ce.size() == 0 || exp_ce[0] != cyc) begin
                    n_bad++; $display("FAIL step_ce: pulse at cycle %0d, want only at 1", cyc - run_start);
                end else begin
                    void'(exp_ce.pop_front());
                    if (state !== ST_STEP) begin n_bad++; $display("FAIL step_state: got %0d want %0d", state, ST_STEP); end
                end
            end
            if (cyc == run_start + 2) begin
                n_cmp++; if (state !== ST_HALT) begin n_bad++; $display("FAIL step_return: got %0d want %0d", state, ST_HALT); end
            end
            @(negedge clk);
        end
        n_cmp++; if (exp_ce.size() != 0) begin n_bad++; $display("FAIL step_missing: got no pulse want 1"); end
        n_cmp++; if (pc !== ADDR_W'(6)) begin n_bad++; $display("FAIL step_pc: got %0d want 6", pc); end
        n_cmp++; if (state !== ST_HALT) begin n_bad++; $display("FAIL step_final_state: got %0d want %0d", state, ST_HALT); end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_priority();
        test_halt_collision();
        test_run_cadence();
        test_reset_mid_run();
        test_breakpoint();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
